// File: rtl/seq_shift_register.sv
// Multi-cycle shifter: loads an operand, then performs one 1-bit shift/rotate/fill step per cycle.
// Optional sticky (OR of shifted-out bits) is built only when SEQ_SHIFT_STICKY_EN is defined.
module seq_shift_register #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             sticky,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_SER   = 2'b11;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] stepped;
  logic             ser_q;
  logic             fill;
  logic             exit_bit;
  logic             accept;
  logic             do_step;

  // start is only honoured in IDLE; hold only freezes SHIFT.
  assign accept  = (state_q == IDLE) && start;
  assign do_step = (state_q == SHIFT) && !hold;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (amount == '0) ? DONE : SHIFT;
      SHIFT:   if (!hold && (cnt_q == AMT_W'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One step of the captured operation: fill bit enters, exit bit leaves.
  always_comb begin
    fill     = 1'b0;
    exit_bit = dir_q ? out_q[WIDTH-1] : out_q[0];
    case (mode_q)
      MODE_ARITH: fill = dir_q ? 1'b0 : out_q[WIDTH-1];
      MODE_LOGIC: fill = 1'b0;
      MODE_ROT:   fill = dir_q ? out_q[WIDTH-1] : out_q[0];
      MODE_SER:   fill = ser_in;
      default:    fill = 1'b0;
    endcase
    stepped = dir_q ? {out_q[WIDTH-2:0], fill} : {fill, out_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_ARITH;
      out_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_q  <= load_data;
        cnt_q  <= amount;
        dir_q  <= dir;
        mode_q <= mode;
        ser_q  <= 1'b0;
      end else if (do_step) begin
        out_q <= stepped;
        cnt_q <= cnt_q - AMT_W'(1);
        ser_q <= exit_bit;
      end
    end
  end

`ifdef SEQ_SHIFT_STICKY_EN
  logic sticky_q;

  // Rotation never loses bits, so it never sets sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (accept) begin
      sticky_q <= 1'b0;
    end else if (do_step && (mode_q != MODE_ROT)) begin
      sticky_q <= sticky_q | exit_bit;
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

  assign out       = out_q;
  assign ser_out   = ser_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shift_register.sv
// Randomized and directed bench for seq_shift_register against a step-level behavioural model.
// Handshake: start is taken on a rising edge in IDLE; done pulses one cycle; busy marks SHIFT.
module tb_seq_shift_register;

  localparam int W  = 16;
  localparam int AW = 5;

`ifdef SEQ_SHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  load_data;
  logic [AW-1:0] amount;
  logic          dir;
  logic [1:0]    mode;
  logic          ser_in;
  logic          hold;
  logic [W-1:0]  out;
  logic          ser_out;
  logic          sticky;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W-1:0] m_out;
  logic         m_ser;
  logic         m_sticky;
  logic         m_dir;
  logic [1:0]   m_mode;

  seq_shift_register #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_data(load_data),
    .amount(amount), .dir(dir), .mode(mode), .ser_in(ser_in), .hold(hold),
    .out(out), .ser_out(ser_out), .sticky(sticky), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one shift step expressed with shift operators on the whole word.
  function automatic void model_step(input logic si);
    logic [W-1:0] x;
    logic         ex;
    x  = m_out;
    ex = m_dir ? x[W-1] : x[0];
    if (!m_dir) begin
      case (m_mode)
        2'b00:   m_out = W'($signed(x) >>> 1);
        2'b01:   m_out = x >> 1;
        2'b10:   m_out = (x >> 1) | (x << (W - 1));
        default: m_out = (x >> 1) | (W'(si) << (W - 1));
      endcase
    end else begin
      case (m_mode)
        2'b10:   m_out = (x << 1) | (x >> (W - 1));
        2'b11:   m_out = (x << 1) | W'(si);
        default: m_out = x << 1;
      endcase
    end
    m_ser = ex;
    if (STICKY_ON && m_mode != 2'b10) m_sticky = m_sticky | ex;
  endfunction

  // Driver: issue one operation and follow it to completion. Caller sits 1 time unit after an edge.
  // hold_kind: 0 never, 1 random, 2 on steps 2 and 3. ser_kind: 0 random, 1 constant one.
  task automatic run_op(input logic [W-1:0] ld, input int amt, input logic d,
                        input logic [1:0] md, input int hold_kind, input int ser_kind);
    int   rem, holds, iter;
    logic h, si;
    start = 1'b1; load_data = ld; amount = AW'(amt); dir = d; mode = md; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    load_data = W'($urandom); amount = AW'($urandom); dir = 1'($urandom); mode = 2'($urandom);
    m_out = ld; m_ser = 1'b0; m_sticky = 1'b0; m_dir = d; m_mode = md;
    rem = amt; holds = 0; iter = 0;
    while (rem > 0) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0 || out !== m_out || ser_out !== m_ser || sticky !== m_sticky) begin
        n_fail++;
        $display("FAIL shift_step%0d: busy=%b done=%b out=%h ser=%b sticky=%b, expected busy=1 done=0 out=%h ser=%b sticky=%b",
                 iter, busy, done, out, ser_out, sticky, m_out, m_ser, m_sticky);
      end
      h = 1'b0;
      if (hold_kind == 1) h = (holds < 4) && ($urandom_range(0, 3) == 0);
      else if (hold_kind == 2) h = (iter == 2 || iter == 3);
      si = (ser_kind == 1) ? 1'b1 : 1'($urandom);
      hold = h; ser_in = si; start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      iter++;
      if (!h) begin
        model_step(si);
        rem--;
      end else begin
        holds++;
      end
    end
    start = 1'b0; hold = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== m_out || ser_out !== m_ser || sticky !== m_sticky) begin
      n_fail++;
      $display("FAIL done_cycle: done=%b busy=%b out=%h ser=%b sticky=%b, expected done=1 busy=0 out=%h ser=%b sticky=%b",
               done, busy, out, ser_out, sticky, m_out, m_ser, m_sticky);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== m_out || ser_out !== m_ser || sticky !== m_sticky) begin
      n_fail++;
      $display("FAIL after_done: done=%b busy=%b out=%h ser=%b sticky=%b, expected done=0 busy=0 out=%h ser=%b sticky=%b",
               done, busy, out, ser_out, sticky, m_out, m_ser, m_sticky);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load_data = '0; amount = '0; dir = 1'b0;
    mode = 2'b00; ser_in = 1'b0; hold = 1'b0;
    #3;
    n_vec++;
    if (out !== '0 || ser_out !== 1'b0 || sticky !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h ser=%b sticky=%b busy=%b done=%b, expected all zero",
               out, ser_out, sticky, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_arith_right();
    run_op(16'hF000, 3, 1'b0, 2'b00, 0, 0);
    n_vec++;
    if (out !== 16'hFE00 || ser_out !== 1'b0 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL arith_right: out=%h ser=%b sticky=%b, expected FE00 0 0", out, ser_out, sticky);
    end
  endtask

  task automatic test_logical_right();
    run_op(16'h8001, 1, 1'b0, 2'b01, 0, 0);
    n_vec++;
    if (out !== 16'h4000 || ser_out !== 1'b1 || sticky !== STICKY_ON) begin
      n_fail++;
      $display("FAIL logical_right: out=%h ser=%b sticky=%b, expected 4000 1 %b", out, ser_out, sticky, STICKY_ON);
    end
  endtask

  task automatic test_rotate_then_zero();
    run_op(16'h8001, 4, 1'b1, 2'b10, 0, 0);
    n_vec++;
    if (out !== 16'h0018 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL rotate_left: out=%h sticky=%b, expected 0018 0", out, sticky);
    end
    run_op(16'h1234, 0, 1'b0, 2'b01, 0, 0);
    n_vec++;
    if (out !== 16'h1234 || ser_out !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_amount: out=%h ser=%b, expected 1234 0", out, ser_out);
    end
  endtask

  task automatic test_serial_hold();
    run_op(16'h0000, 4, 1'b1, 2'b11, 2, 1);
    n_vec++;
    if (out !== 16'h000F) begin
      n_fail++;
      $display("FAIL serial_hold: out=%h, expected 000F", out);
    end
  endtask

  task automatic test_saturate();
    run_op(16'h8421, 20, 1'b0, 2'b00, 0, 0);
    n_vec++;
    if (out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturate_arith: out=%h, expected FFFF", out);
    end
    run_op(16'h8421, 20, 1'b0, 2'b01, 0, 0);
    n_vec++;
    if (out !== 16'h0000 || ser_out !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate_logical: out=%h ser=%b, expected 0000 0", out, ser_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_op(W'($urandom), $urandom_range(0, 31), 1'($urandom), 2'($urandom), 1, 0);
  endtask

  task automatic test_reset_abort();
    start = 1'b1; load_data = 16'hA5A5; amount = AW'(8); dir = 1'b1; mode = 2'b01; hold = 1'b0;
    @(posedge clk); #1;
    m_out = 16'hA5A5; m_ser = 1'b0; m_sticky = 1'b0; m_dir = 1'b1; m_mode = 2'b01;
    for (int s = 0; s < 3; s++) begin
      start = 1'b1; load_data = W'($urandom); amount = AW'($urandom); dir = 1'b0; mode = 2'b10;
      @(posedge clk); #1;
      model_step(1'b0);
      n_vec++;
      if (out !== m_out || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL start_ignored%0d: out=%h busy=%b, expected %h 1", s, out, busy, m_out);
      end
    end
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: out=%h busy=%b done=%b ser=%b sticky=%b, expected all zero",
               out, busy, done, ser_out, sticky);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_done_after_abort%0d: done=%b busy=%b, expected 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_first_start_after_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(16'h00F0, 2, 1'b1, 2'b01, 0, 0);
    n_vec++;
    if (out !== 16'h03C0) begin
      n_fail++;
      $display("FAIL first_start: out=%h, expected 03C0", out);
    end
  endtask

  initial begin
    test_reset();
    test_arith_right();
    test_logical_right();
    test_rotate_then_zero();
    test_serial_hold();
    test_saturate();
    test_random();
    test_reset_abort();
    test_first_start_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_register.md
SEQ_SHIFT_REGISTER -- requirements
Module: seq_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (>=2).
REQ-002 SHALL have parameter AMT_W, default 4, width of the shift-amount field.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port load_data  input  WIDTH  operand captured on an accepted start.
REQ-007 SHALL have port amount  input  AMT_W  number of 1-bit shift steps, captured on an accepted start.
REQ-008 SHALL have port dir  input  1  0 = right, 1 = left; captured on an accepted start.
REQ-009 SHALL have port mode  input  2  00 arithmetic, 01 logical, 10 rotate, 11 serial-fill; captured on an accepted start.
REQ-010 SHALL have port ser_in  input  1  fill bit for serial-fill mode, sampled on every shift step.
REQ-011 SHALL have port hold  input  1  when high in SHIFT, suspends stepping.
REQ-012 SHALL have port out  output  WIDTH  working/result register.
REQ-013 SHALL have port ser_out  output  1  bit that left the register on the most recent step.
REQ-014 SHALL have port sticky  output  1  OR of all bits shifted out during the current operation.
REQ-015 SHALL have port busy  output  1  high in states LOAD-accepted through SHIFT.
REQ-016 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 In IDLE with start=1, SHALL load out<=load_data, capture amount/dir/mode into internal registers, clear sticky and ser_out, and go to SHIFT if amount!=0, else DONE.
REQ-019 In SHIFT with hold=0, SHALL perform exactly one 1-bit step per cycle and decrement the step counter; it SHALL go to DONE on the step that brings the counter to 0.
REQ-020 In SHIFT with hold=1, SHALL hold out, counter, ser_out and sticky unchanged.
REQ-021 Right step fill: arithmetic = out[WIDTH-1]; logical = 0; rotate = out[0]; serial-fill = ser_in.
REQ-022 Left step fill: arithmetic = 0, logical = 0, rotate = out[WIDTH-1], serial-fill = ser_in.
REQ-023 Each step SHALL set ser_out to the exiting bit (out[0] right, out[WIDTH-1] left) and OR it into sticky; in rotate mode sticky SHALL remain 0.
REQ-024 DONE SHALL last exactly one cycle with done=1, busy=0, then return to IDLE.
REQ-025 busy SHALL be 1 exactly while in SHIFT; 0 in IDLE and DONE.
REQ-026 Latency: with hold=0, done SHALL assert amount+1 cycles after the cycle start was sampled (1 cycle when amount=0).
REQ-027 out, ser_out and sticky SHALL hold their values after DONE until the next accepted start.
REQ-028 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-029 amount >= WIDTH SHALL be legal; steps continue normally (arithmetic right saturates to all sign bits, logical to zero).
REQ-030 Inputs load_data, amount, dir, mode SHALL have no effect after capture.

Reset
REQ-031 reset=1 SHALL immediately, without clk, force state IDLE, out=0, ser_out=0, sticky=0, busy=0, done=0, counter=0.
REQ-032 Reset asserted mid-operation SHALL abort it; no done pulse SHALL be produced for the aborted operation.
REQ-033 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-034 Macro SEQ_SHIFT_STICKY_EN: when defined, sticky SHALL behave per REQ-023; when undefined, sticky SHALL be constant 0 and no sticky storage SHALL be built; all other behaviour identical.

Verification
REQ-035 WIDTH=16, load 16'hF000, amount=3, dir=0, mode=00 -> done at cycle 4, out=16'hFE00, ser_out=0, sticky=0.
REQ-036 load 16'h8001, amount=1, dir=0, mode=01 -> out=16'h4000, ser_out=1, sticky=1 (0 if macro undefined).
REQ-037 load 16'h8001, amount=4, dir=1, mode=10 -> out=16'h0018, sticky=0; then amount=0 start -> done next cycle, out=load_data.
REQ-038 load 16'h0000, amount=4, dir=1, mode=11, ser_in=1 each step, hold=1 for 2 cycles mid-run -> out=16'h000F, done at cycle 7.
REQ-039 start with amount=8, reset pulse at step 3 -> out=0, busy=0, no done; start during SHIFT ignored (captured values unchanged).
